// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and loads IF/ID. A 1-entry skid buffer catches a response that lands during a stall.
module fetch_stage #(
  parameter int unsigned PC_W = 9,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  output logic [PC_W-1:0] IfId_Pc,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid
);

  typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;

  state_t          state, state_d;
  logic [PC_W-1:0] pc, pc_d;
  logic [PC_W-1:0] pend_pc, pend_pc_d;
  logic            skid_valid, skid_valid_d;
  logic [PC_W-1:0] skid_pc, skid_pc_d;
  logic [31:0]     skid_instr, skid_instr_d;
  logic [PC_W-1:0] ifid_pc_d;
  logic [31:0]     ifid_instr_d;
  logic            ifid_valid_d;

  // Only the word-aligned low PC bits of the redirect target are meaningful.
  logic unused_brpc;
  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

  assign imem_addr = pc;

  // Next-state, request issue and IF/ID/skid update.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    pend_pc_d    = pend_pc;
    skid_valid_d = skid_valid;
    skid_pc_d    = skid_pc;
    skid_instr_d = skid_instr;
    ifid_pc_d    = IfId_Pc;
    ifid_instr_d = IfId_Instr;
    ifid_valid_d = IfId_Valid;

    imem_req = !reset && !PcSel && !Stall && !skid_valid &&
               (state == IDLE || imem_rvalid);

    if (PcSel) begin
      pc_d         = {BrPC[PC_W-1:2], 2'b00};
      ifid_pc_d    = '0;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      // A request still in flight must have its response dropped later.
      if (state != IDLE && !imem_rvalid) state_d = SQUASH;
      else                               state_d = IDLE;
    end else begin
      if (state == BUSY && imem_rvalid) begin
        if (Stall) begin
          skid_valid_d = 1'b1;
          skid_pc_d    = pend_pc;
          skid_instr_d = imem_rdata;
        end else begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pend_pc;
          ifid_instr_d = imem_rdata;
        end
      end
      if (!Stall && skid_valid) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = skid_pc;
        ifid_instr_d = skid_instr;
        skid_valid_d = 1'b0;
      end
      if (state != IDLE && imem_rvalid) state_d = IDLE;
      if (imem_req) begin
        pend_pc_d = pc;
        pc_d      = pc + PC_W'(4);
        state_d   = BUSY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      pend_pc    <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP;
      IfId_Pc    <= '0;
      IfId_Instr <= NOP;
      IfId_Valid <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pend_pc    <= pend_pc_d;
      skid_valid <= skid_valid_d;
      skid_pc    <= skid_pc_d;
      skid_instr <= skid_instr_d;
      IfId_Pc    <= ifid_pc_d;
      IfId_Instr <= ifid_instr_d;
      IfId_Valid <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small addr-tagged instruction memory model.
module tb_fetch_stage;

  localparam int unsigned PC_W = 9;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            reset;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Stall;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_rvalid;
  logic [PC_W-1:0] IfId_Pc;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;

  fetch_stage #(.PC_W(PC_W), .NOP(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Stall      (Stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .IfId_Pc    (IfId_Pc),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory model state: one outstanding request, answered after mem_wait idle cycles.
  logic            mo;
  logic [PC_W-1:0] mo_addr;
  int              mo_cnt;
  int              mem_wait;
  logic            req_s;
  logic [PC_W-1:0] addr_s;

  function automatic logic [31:0] tag(input logic [PC_W-1:0] a);
    return 32'hC0DE_0000 | {23'b0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string name, input logic v, input logic [PC_W-1:0] p,
                          input logic [31:0] ins);
    chk({name, "_valid"}, {31'b0, IfId_Valid}, {31'b0, v});
    chk({name, "_pc"},    {23'b0, IfId_Pc},    {23'b0, p});
    chk({name, "_instr"}, IfId_Instr,          ins);
  endtask

  // One clock cycle: memory drives its response, request is sampled, then the edge.
  task automatic tick();
    imem_rvalid = mo && (mo_cnt == 0);
    imem_rdata  = imem_rvalid ? tag(mo_addr) : 32'h0;
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    chk("single_outstanding", {31'b0, req_s && mo && !imem_rvalid}, 32'd0);
    @(posedge clk);
    if (imem_rvalid) mo = 1'b0;
    else if (mo)     mo_cnt--;
    if (req_s) begin
      mo      = 1'b1;
      mo_addr = addr_s;
      mo_cnt  = mem_wait;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  task automatic chk_req(input string name, input logic r, input logic [PC_W-1:0] a);
    chk({name, "_req"}, {31'b0, req_s}, {31'b0, r});
    if (r) chk({name, "_addr"}, {23'b0, addr_s}, {23'b0, a});
  endtask

  initial begin
    reset = 1'b1; PcSel = 1'b0; BrPC = 32'h0; Stall = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    mo = 1'b0; mo_addr = '0; mo_cnt = 0; mem_wait = 0;
    req_s = 1'b0; addr_s = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk_ifid("rst", 1'b0, 9'h000, NOP);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait streaming
    tick(); chk_req("s0", 1'b1, 9'h000); chk_ifid("s0", 1'b0, 9'h000, NOP);
    tick(); chk_req("s1", 1'b1, 9'h004); chk_ifid("s1", 1'b1, 9'h000, tag(9'h000));
    tick(); chk_req("s2", 1'b1, 9'h008); chk_ifid("s2", 1'b1, 9'h004, tag(9'h004));

    // Stall while fetch of 8 is in flight
    Stall = 1'b1;
    tick(); chk_req("st0", 1'b0, 9'h000); chk_ifid("st0", 1'b1, 9'h004, tag(9'h004));
    tick(); chk_req("st1", 1'b0, 9'h000); chk_ifid("st1", 1'b1, 9'h004, tag(9'h004));
    tick(); chk_req("st2", 1'b0, 9'h000); chk_ifid("st2", 1'b1, 9'h004, tag(9'h004));
    Stall = 1'b0;
    tick(); chk_req("rel0", 1'b0, 9'h000); chk_ifid("rel0", 1'b1, 9'h008, tag(9'h008));
    mem_wait = 2;
    tick(); chk_req("rel1", 1'b1, 9'h00C); chk_ifid("rel1", 1'b1, 9'h008, tag(9'h008));

    // Redirect to 0x40 while BUSY, response for 12 delayed by 2 cycles
    PcSel = 1'b1; BrPC = 32'h0000_0040;
    tick(); chk_req("br0", 1'b0, 9'h000); chk_ifid("br0", 1'b0, 9'h000, NOP);
    PcSel = 1'b0; mem_wait = 0;
    tick(); chk_req("br1", 1'b0, 9'h000); chk_ifid("br1", 1'b0, 9'h000, NOP);
    tick(); chk_req("br2", 1'b1, 9'h040); chk_ifid("br2", 1'b0, 9'h000, NOP);
    tick(); chk_req("br3", 1'b1, 9'h044); chk_ifid("br3", 1'b1, 9'h040, tag(9'h040));

    // Redirect coinciding with response, unaligned target near the top of memory
    PcSel = 1'b1; BrPC = 32'h0000_01FE;
    tick(); chk_req("wr0", 1'b0, 9'h000); chk_ifid("wr0", 1'b0, 9'h000, NOP);
    PcSel = 1'b0;
    tick(); chk_req("wr1", 1'b1, 9'h1FC); chk_ifid("wr1", 1'b0, 9'h000, NOP);
    tick(); chk_req("wr2", 1'b1, 9'h000); chk_ifid("wr2", 1'b1, 9'h1FC, tag(9'h1FC));

    // Fill skid, then redirect and stall together
    Stall = 1'b1;
    tick(); chk_req("fs0", 1'b0, 9'h000); chk_ifid("fs0", 1'b1, 9'h1FC, tag(9'h1FC));
    PcSel = 1'b1; BrPC = 32'h0000_0080;
    tick(); chk_req("fs1", 1'b0, 9'h000); chk_ifid("fs1", 1'b0, 9'h000, NOP);
    PcSel = 1'b0; Stall = 1'b0;
    tick(); chk_req("fs2", 1'b1, 9'h080); chk_ifid("fs2", 1'b0, 9'h000, NOP);
    tick(); chk_req("fs3", 1'b1, 9'h084); chk_ifid("fs3", 1'b1, 9'h080, tag(9'h080));

    // Async reset while BUSY, between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk_ifid("ar", 1'b0, 9'h000, NOP);
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    mo = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(); chk_req("ar0", 1'b1, 9'h000); chk_ifid("ar0", 1'b0, 9'h000, NOP);
    tick(); chk_req("ar1", 1'b1, 9'h004); chk_ifid("ar1", 1'b1, 9'h000, tag(9'h000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
